// File: rtl/psk_modulator_v3.sv
// BPSK/QPSK carrier modulator: latches one frame, plays sine-table samples per symbol
// with a phase offset chosen per symbol, then holds a zero-output guard interval.
`timescale 1ns/1ps
module psk_modulator_v3 #(
    parameter int unsigned BITS               = 32,
    parameter int unsigned SIGNAL_WIDTH       = 8,
    parameter int unsigned SAMPLES_PER_SYMBOL = 16,
    parameter int unsigned GUARD_CYCLES       = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [BITS-1:0]                data,
    input  logic                           mode,
    input  logic                           data_valid,
    output logic                           data_ready,
    output logic signed [SIGNAL_WIDTH-1:0] signal,
    output logic                           signal_valid,
    output logic                           symbol_strobe,
    output logic                           done
);

    localparam int unsigned SPS   = SAMPLES_PER_SYMBOL;
    localparam int unsigned QTR   = SPS / 4;
    localparam int unsigned IW    = $clog2(SPS);
    localparam int unsigned KW    = IW + 1;
    localparam int unsigned SYW   = (BITS > 2) ? $clog2(BITS) : 1;
    localparam int unsigned GW    = $clog2(GUARD_CYCLES + 1) + 1;
    localparam int unsigned GLAST = (GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0;

    typedef enum logic [1:0] {IDLE, RUN, GUARD} state_e;

    // Elaboration-time sine entry, rounded half away from zero.
    function automatic int sin_entry(input int k);
        real amp;
        real val;
        amp = real'((1 << (SIGNAL_WIDTH - 1)) - 1);
        val = amp * $sin(2.0 * 3.14159265358979323846 * real'(k) / real'(SPS));
        if (val >= 0.0) return $rtoi(val + 0.5);
        else            return -$rtoi(-val + 0.5);
    endfunction

    logic signed [SIGNAL_WIDTH-1:0] lut [SPS];

    for (genvar g = 0; g < SPS; g++) begin : g_lut
        assign lut[g] = SIGNAL_WIDTH'(sin_entry(g));
    end

    state_e          state_q, state_d;
    logic [IW-1:0]   k_q, k_d;
    logic [SYW-1:0]  sym_q, sym_d, last_sym;
    logic [BITS-1:0] sh_q, sh_d;
    logic            mode_q, mode_d;
    logic [GW-1:0]   gcnt_q, gcnt_d;
    logic            done_d;

    logic [1:0]      pair_d;
    logic [1:0]      phase_d;
    logic [KW-1:0]   sum_d;
    logic [IW-1:0]   idx_d;
    logic            valid_d;

    logic signed [SIGNAL_WIDTH-1:0] signal_q, signal_d;
    logic            signal_valid_q, symbol_strobe_q, done_q, ready_q;

    assign last_sym = mode_q ? SYW'(BITS / 2 - 1) : SYW'(BITS - 1);

    // Next-state: frame acceptance, sample/symbol sequencing and guard countdown.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        sym_d   = sym_q;
        sh_d    = sh_q;
        mode_d  = mode_q;
        gcnt_d  = gcnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (data_valid) begin
                    state_d = RUN;
                    k_d     = '0;
                    sym_d   = '0;
                    sh_d    = data;
                    mode_d  = mode;
                end
            end
            RUN: begin
                if (k_q == IW'(SPS - 1)) begin
                    k_d = '0;
                    if (sym_q == last_sym) begin
                        done_d  = 1'b1;
                        gcnt_d  = '0;
                        state_d = (GUARD_CYCLES == 0) ? IDLE : GUARD;
                    end else begin
                        sym_d = sym_q + SYW'(1);
                        sh_d  = mode_q ? (sh_q << 2) : (sh_q << 1);
                    end
                end else begin
                    k_d = k_q + IW'(1);
                end
            end
            GUARD: begin
                if (gcnt_q == GW'(GLAST)) state_d = IDLE;
                else                      gcnt_d  = gcnt_q + GW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // Output samples are derived from next-state so they appear one cycle after acceptance.
    always_comb begin
        pair_d  = sh_d[BITS-1 -: 2];
        phase_d = 2'd0;
        if (!mode_d) begin
            phase_d = sh_d[BITS-1] ? 2'd0 : 2'd2;
        end else begin
            case (pair_d)
                2'b00:   phase_d = 2'd0;
                2'b01:   phase_d = 2'd1;
                2'b11:   phase_d = 2'd2;
                default: phase_d = 2'd3;
            endcase
        end
        sum_d = KW'(k_d) + KW'(phase_d) * KW'(QTR);
        if (sum_d >= KW'(SPS)) sum_d = sum_d - KW'(SPS);
        idx_d    = IW'(sum_d);
        valid_d  = (state_d == RUN);
        signal_d = valid_d ? lut[idx_d] : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            k_q             <= '0;
            sym_q           <= '0;
            sh_q            <= '0;
            mode_q          <= 1'b0;
            gcnt_q          <= '0;
            signal_q        <= '0;
            signal_valid_q  <= 1'b0;
            symbol_strobe_q <= 1'b0;
            done_q          <= 1'b0;
            ready_q         <= 1'b1;
        end else begin
            state_q         <= state_d;
            k_q             <= k_d;
            sym_q           <= sym_d;
            sh_q            <= sh_d;
            mode_q          <= mode_d;
            gcnt_q          <= gcnt_d;
            signal_q        <= signal_d;
            signal_valid_q  <= valid_d;
            symbol_strobe_q <= valid_d && (k_d == '0);
            done_q          <= done_d;
            ready_q         <= (state_d == IDLE);
        end
    end

    assign signal        = signal_q;
    assign signal_valid  = signal_valid_q;
    assign symbol_strobe = symbol_strobe_q;
    assign done          = done_q;
    assign data_ready    = ready_q;

endmodule

// File: tb/tb_psk_modulator_v3.sv
// Directed bench for psk_modulator_v3: table of hand-computed samples plus
// back-to-back, mid-frame reset and zero-guard sequences.
`timescale 1ns/1ps
module tb_psk_modulator_v3;

    localparam int unsigned SPS = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data, data0;
    logic       mode, mode0, dv, dv0;
    logic       ready, sv, ss, dn;
    logic       ready0, sv0, ss0, dn0;
    logic signed [7:0] sig, sig0;

    int n_cmp = 0;
    int n_err = 0;
    int cap [128];

    // round(127*sin(2*pi*k/16))
    int sin_t [16] = '{0, 49, 90, 117, 127, 117, 90, 49, 0, -49, -90, -117, -127, -117, -90, -49};

    typedef struct {
        logic [7:0] d;
        logic       m;
        int         sym;
        int         k;
        int         exp;
    } vec_t;
    vec_t vecs [14];

    always #5 clk = ~clk;

    psk_modulator_v3 #(.BITS(8), .SIGNAL_WIDTH(8), .SAMPLES_PER_SYMBOL(16), .GUARD_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .data(data), .mode(mode), .data_valid(dv),
        .data_ready(ready), .signal(sig), .signal_valid(sv), .symbol_strobe(ss), .done(dn));

    psk_modulator_v3 #(.BITS(8), .SIGNAL_WIDTH(8), .SAMPLES_PER_SYMBOL(16), .GUARD_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .data(data0), .mode(mode0), .data_valid(dv0),
        .data_ready(ready0), .signal(sig0), .signal_valid(sv0), .symbol_strobe(ss0), .done(dn0));

    function automatic int model(input logic [7:0] d, input logic m, input int i);
        int sym, k, p;
        logic [1:0] pr;
        sym = i / 16;
        k   = i % 16;
        if (!m) begin
            p = d[3'(7 - sym)] ? 0 : 2;
        end else begin
            pr = {d[3'(7 - 2 * sym)], d[3'(6 - 2 * sym)]};
            case (pr)
                2'b00:   p = 0;
                2'b01:   p = 1;
                2'b11:   p = 2;
                default: p = 3;
            endcase
        end
        return sin_t[(k + p * 4) % 16];
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one frame on dut, check every sample, the done pulse, then scramble inputs.
    task automatic run_frame(input logic [7:0] d, input logic m);
        int guard;
        int nsamp;
        nsamp = m ? 64 : 128;
        data  = d;
        mode  = m;
        dv    = 1'b1;
        guard = 0;
        while (ready !== 1'b1 && guard < 300) begin
            tick();
            guard++;
        end
        if (guard >= 300) chk("accept_timeout", 0, 1);
        tick();
        dv   = 1'b0;
        data = ~d;
        mode = ~m;
        for (int i = 0; i < nsamp; i++) begin
            cap[i] = int'(sig);
            chk($sformatf("frame_sample[%0d]", i),
                int'({sv, ss, dn, ready, sig}),
                int'({1'b1, (i % 16) == 0, 1'b0, 1'b0, 8'(model(d, m, i))}));
            tick();
        end
        chk("done_pulse", int'({dn, sv, ss, ready, sig}), int'({4'b1000, 8'd0}));
        tick();
        chk("done_single", int'(dn), 0);
    endtask

    initial begin
        int cnt;
        int dones;

        vecs[0]  = '{8'hA5, 1'b0, 0, 4, 127};
        vecs[1]  = '{8'hA5, 1'b0, 1, 4, -127};
        vecs[2]  = '{8'hA5, 1'b0, 0, 0, 0};
        vecs[3]  = '{8'hA5, 1'b0, 1, 1, -49};
        vecs[4]  = '{8'hA5, 1'b0, 2, 3, 117};
        vecs[5]  = '{8'hA5, 1'b0, 7, 12, -127};
        vecs[6]  = '{8'h1E, 1'b1, 0, 0, 0};
        vecs[7]  = '{8'h1E, 1'b1, 1, 0, 127};
        vecs[8]  = '{8'h1E, 1'b1, 2, 0, 0};
        vecs[9]  = '{8'h1E, 1'b1, 3, 0, -127};
        vecs[10] = '{8'h1E, 1'b1, 1, 2, 90};
        vecs[11] = '{8'h1E, 1'b1, 3, 5, 49};
        vecs[12] = '{8'hB4, 1'b1, 0, 3, -49};
        vecs[13] = '{8'hB4, 1'b1, 2, 6, -90};

        reset = 1'b1;
        data  = 8'h00; mode  = 1'b0; dv  = 1'b0;
        data0 = 8'h00; mode0 = 1'b0; dv0 = 1'b0;
        tick();
        tick();
        chk("reset_state", int'({sv, ss, dn, ready, sig}), int'({4'b0001, 8'd0}));
        chk("reset_state0", int'({sv0, ss0, dn0, ready0, sig0}), int'({4'b0001, 8'd0}));
        reset = 1'b0;
        tick();

        // Table-driven samples, each against a freshly run frame.
        foreach (vecs[v]) begin
            run_frame(vecs[v].d, vecs[v].m);
            chk($sformatf("vec%0d_sym%0d_k%0d", v, vecs[v].sym, vecs[v].k),
                cap[vecs[v].sym * SPS + vecs[v].k], vecs[v].exp);
        end

        // Back-to-back acceptance period with data_valid held.
        data = 8'hA5; mode = 1'b0; dv = 1'b1;
        cnt = 0;
        while (ready !== 1'b1 && cnt < 300) begin tick(); cnt++; end
        tick();
        cnt = 1;
        while (ready !== 1'b1 && cnt < 400) begin tick(); cnt++; end
        chk("b2b_period", cnt, 133);
        tick();
        chk("b2b_second_start", int'({sv, ss, ready, sig}), int'({3'b110, 8'(model(8'hA5, 1'b0, 0))}));
        dv = 1'b0;

        // Reset at cycle 50 of a frame aborts without done.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        data = 8'h3C; mode = 1'b0; dv = 1'b1;
        tick();
        dv = 1'b0;
        for (int i = 1; i < 50; i++) tick();
        chk("pre_abort_running", int'(sv), 1);
        reset = 1'b1;
        tick();
        chk("abort_outputs", int'({sv, ss, dn, ready, sig}), int'({4'b0001, 8'd0}));
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 140; i++) begin
            if (dn === 1'b1 || sv === 1'b1) dones++;
            tick();
        end
        chk("abort_no_done", dones, 0);
        run_frame(8'h3C, 1'b0);

        // Reset has priority over a simultaneous offer.
        reset = 1'b1; dv = 1'b1;
        tick();
        reset = 1'b0; dv = 1'b0;
        chk("reset_beats_valid", int'({sv, ready}), int'(2'b01));
        tick();
        chk("reset_beats_valid_next", int'(sv), 0);

        // Zero guard: done with data_ready, next frame starts the cycle after.
        data0 = 8'h5A; mode0 = 1'b0; dv0 = 1'b1;
        cnt = 0;
        while (ready0 !== 1'b1 && cnt < 300) begin tick(); cnt++; end
        tick();
        data0 = 8'h40; mode0 = 1'b1;
        for (int i = 0; i < 128; i++) begin
            if (i % 37 == 0)
                chk($sformatf("g0_sample[%0d]", i), int'({sv0, sig0}),
                    int'({1'b1, 8'(model(8'h5A, 1'b0, i))}));
            tick();
        end
        chk("g0_done_ready", int'({dn0, ready0, sv0}), int'(3'b110));
        tick();
        dv0 = 1'b0;
        chk("g0_next_frame", int'({sv0, ss0, dn0, ready0, sig0}), int'({4'b1100, 8'd127}));
        chk("g0_next_model", int'(sig0), model(8'h40, 1'b1, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/psk_modulator_v3.md
PSK_MODULATOR_V3 -- requirements
Module: psk_modulator_v3

Interface
REQ-001 SHALL have parameter BITS, default 32: frame length in bits; even, ≥2.
REQ-002 SHALL have parameter SIGNAL_WIDTH, default 8: signed output sample width.
REQ-003 SHALL have parameter SAMPLES_PER_SYMBOL, default 16: carrier samples per symbol; multiple of 4, ≥4.
REQ-004 SHALL have parameter GUARD_CYCLES, default 4: zero-output cycles after each frame; 0 allowed.
REQ-005 SHALL have port clk, input, 1: sole clock, all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port data, input, BITS: frame payload, sent MSB first.
REQ-008 SHALL have port mode, input, 1: 0 = BPSK (1 bit/symbol), 1 = QPSK (2 bits/symbol).
REQ-009 SHALL have port data_valid, input, 1: payload offered.
REQ-010 SHALL have port data_ready, output, 1: block accepts a frame this cycle.
REQ-011 SHALL have port signal, output, SIGNAL_WIDTH: signed two's-complement carrier sample.
REQ-012 SHALL have port signal_valid, output, 1: signal holds a modulated sample.
REQ-013 SHALL have port symbol_strobe, output, 1: high on the first sample of each symbol.
REQ-014 SHALL have port done, output, 1: single-cycle pulse at frame end.

Function
REQ-015 SHALL use states IDLE, RUN, GUARD; data_ready = (state == IDLE).
REQ-016 SHALL accept a frame on any cycle with data_valid && data_ready, latching data and mode and moving to RUN; mode and data changes after acceptance have no effect.
REQ-017 SHALL emit the first sample of the frame, with signal_valid = 1 and symbol_strobe = 1, in the cycle after acceptance (latency 1).
REQ-018 SHALL hold an internal table entry sin_k = round((2^(SIGNAL_WIDTH-1)-1) * sin(2*pi*k/SAMPLES_PER_SYMBOL)), k = 0..SAMPLES_PER_SYMBOL-1.
REQ-019 SHALL output sin_((k + p*SAMPLES_PER_SYMBOL/4) mod SAMPLES_PER_SYMBOL), where k is the sample index within the symbol (0..SPS-1) and p is the phase index.
REQ-020 In BPSK, a bit of 1 SHALL give p = 0 and a bit of 0 SHALL give p = 2 (180 degrees).
REQ-021 In QPSK, the bit pair {b[n], b[n-1]}, taken MSB-first, SHALL map by Gray code: 00 -> p0, 01 -> p1, 11 -> p2, 10 -> p3.
REQ-022 Symbol counts: BPSK SHALL send BITS symbols and QPSK SHALL send BITS/2 symbols, each exactly SAMPLES_PER_SYMBOL cycles long, with no gaps between symbols.
REQ-023 The sample counter SHALL wrap from SPS-1 to 0; symbol_strobe SHALL be high when the counter is 0 in RUN.
REQ-024 After the last sample of the last symbol, the block SHALL enter GUARD for GUARD_CYCLES cycles, or go directly to IDLE when GUARD_CYCLES = 0.
REQ-025 done SHALL pulse in the first cycle after the last sample: the first GUARD cycle, or the first IDLE cycle when GUARD_CYCLES = 0.
REQ-026 Outside RUN, signal SHALL be 0 and signal_valid and symbol_strobe SHALL be 0.
REQ-027 signal, signal_valid and symbol_strobe SHALL all be registered outputs.
REQ-028 data_valid asserted during RUN or GUARD SHALL be ignored; the offering source holds it until data_ready is high.
REQ-029 Back-to-back frames: with data_valid held high, the next acceptance SHALL occur in the first IDLE cycle, giving a frame period of symbols*SPS + GUARD_CYCLES + 1 cycles.

Reset
REQ-030 While reset is high, the block SHALL enter IDLE on the next edge and clear all counters.
REQ-031 Reset values SHALL be: signal = 0, signal_valid = 0, symbol_strobe = 0, done = 0, data_ready = 1 from the first cycle after reset.
REQ-032 Reset mid-frame (RUN or GUARD) SHALL abort the frame without a done pulse.
REQ-033 reset and data_valid high together SHALL not accept the frame; reset has priority.

Verification
REQ-034 BPSK, BITS=8, SPS=16, W=8, GUARD=4, data=8'hA5: 128 valid samples; symbol 0 sample 4 = +127; symbol 1 sample 4 = -127; done at cycle 129 after acceptance.
REQ-035 QPSK, data=8'b00011110: four symbols with p = 0, 1, 2, 3; sample 0 of each = 0, +127, 0, -127.
REQ-036 data_valid held high: acceptances 133 cycles apart with BPSK, BITS=8, SPS=16, GUARD=4; data_ready low throughout RUN and GUARD.
REQ-037 Reset asserted at cycle 50 of a frame: signal = 0 and signal_valid = 0 on the next cycle; no done pulse; data_ready = 1; a new frame then runs correctly.
REQ-038 GUARD_CYCLES=0: done coincides with data_ready = 1; a frame offered in that cycle starts with no zero gap.
REQ-039 mode and data changed during RUN: output matches the latched frame exactly, compared sample-by-sample against a reference model.
